peripheral_spram_ahb3_master: RTL and testbench
===============================================

PERIPHERAL_SPRAM_AHB3_MASTER -- requirements
Module: peripheral_spram_ahb3_master

Interface
REQ-001 SHALL have parameter PLEN, default 8, address width.
REQ-002 SHALL have parameter XLEN, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, watchdog limit in consecutive HREADY-low cycles.
REQ-004 SHALL have ports, clock and reset first: HCLK in 1 clock; HRESET in 1 reset, synchronous, active-high.
REQ-005 SHALL have request ports: req_valid in 1; req_ready out 1; req_write in 1; req_addr in PLEN; req_wdata in XLEN; req_size in 3 (HSIZE encoding).
REQ-006 SHALL have response ports: rsp_valid out 1 (one-cycle pulse, no backpressure); rsp_rdata out XLEN; rsp_error out 1; rsp_timeout out 1.
REQ-007 SHALL have AHB3-Lite master ports: HSEL out 1; HADDR out PLEN; HWDATA out XLEN; HRDATA in XLEN; HWRITE out 1; HSIZE out 3; HBURST out 3; HPROT out 4; HTRANS out 2; HMASTLOCK out 1; HREADY in 1; HRESP in 1.

Function
REQ-008 SHALL accept a request when req_valid && req_ready; req_ready = (address phase empty || HREADY) && state != ERR.
REQ-009 SHALL drive an accepted request as a registered address phase in the next cycle: HTRANS=NONSEQ(10), HSEL=1, HADDR/HWRITE/HSIZE from request; otherwise HTRANS=IDLE(00), HSEL=0.
REQ-010 SHALL hold address-phase outputs stable while HREADY=0.
REQ-011 SHALL move the address phase to the data phase on the edge where HREADY=1, driving HWDATA with that request's wdata for the whole data phase.
REQ-012 SHALL pipeline: a new address phase overlaps the current data phase; back-to-back requests achieve one transfer per cycle at HREADY=1.
REQ-013 SHALL complete the data phase on HREADY=1, pulsing rsp_valid with rsp_rdata=HRDATA (reads) or 0 (writes), rsp_error=HRESP.
REQ-014 SHALL drive HBURST=SINGLE(000), HPROT=0011, HMASTLOCK=0 constantly.
REQ-015 SHALL implement states IDLE (no phases), BUSY (address and/or data phase valid), ERR (second error cycle).
REQ-016 SHALL on HRESP=1 && HREADY=0 in data phase enter ERR, force HTRANS=IDLE next cycle while keeping the pending address-phase request held.
REQ-017 SHALL in ERR complete on HREADY=1 (rsp_valid, rsp_error=1), then re-issue the held request as NONSEQ, returning to BUSY (or IDLE if none).
REQ-018 SHALL treat req_size > XLEN/8 bytes as unsupported: accept it and respond rsp_error=1 without bus activity.

Reset
REQ-019 SHALL on HRESET=1 at a clock edge clear all phases, enter IDLE, drive HTRANS=00, HSEL=0, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0, rsp_valid=0, rsp_error=0, rsp_timeout=0, req_ready=0.
REQ-020 SHALL on reset mid-transfer drop all in-flight requests without emitting a response; req_ready rises one cycle after reset deasserts.

Configuration
REQ-021 SHALL, with macro PERIPHERAL_SPRAM_AHB3_MASTER_TIMEOUT_EN defined, count consecutive HREADY=0 cycles during data phase; on reaching TIMEOUT_CYCLES pulse rsp_valid with rsp_error=1, rsp_timeout=1, drop both phases and enter IDLE.
REQ-022 SHALL, without that macro, have no counter, rsp_timeout tied 0, and wait indefinitely for HREADY.

Structure
REQ-023 SHALL place HTRANS, HBURST, HSIZE, HPROT encodings and the state enum in shared package peripheral_ahb3_pkg.
REQ-024 SHALL be one module; optional sub-module peripheral_spram_ahb3_master_watchdog holds the timeout counter.

Verification
REQ-025 Write 0x12345678 to 0x10, slave HREADY=1 -> HTRANS=NONSEQ cycle 1, HWDATA=0x12345678 cycle 2, rsp_valid cycle 2 with error=0.
REQ-026 Four back-to-back reads 0x00,0x04,0x08,0x0C from preloaded SPRAM -> four consecutive rsp_valid cycles, data in order.
REQ-027 Slave inserts 3 wait states on read of 0x20 -> HADDR/HTRANS of next request stable 3 cycles, single rsp_valid after wait.
REQ-028 Slave two-cycle ERROR on write 0x30 with read 0x34 pending -> HTRANS=IDLE in second error cycle, rsp_error=1, then 0x34 re-issued and completes error=0.
REQ-029 TIMEOUT_EN, TIMEOUT_CYCLES=16, HREADY held 0 -> rsp_valid with error=1, timeout=1 on 16th wait cycle, HTRANS=IDLE after.
REQ-030 HRESET asserted during a data-phase wait -> next cycle all outputs at REQ-019 values, no rsp_valid.

Source files
------------

// File: rtl/peripheral_ahb3_pkg.sv
// Purpose: shared AHB3-Lite encodings and master FSM state type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package peripheral_ahb3_pkg;

    // HTRANS encodings used by a single-transfer master
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // HBURST: only single transfers are generated
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // HSIZE encodings (bytes = 2**HSIZE)
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // HPROT: data access, privileged, non-bufferable, non-cacheable
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    // IDLE: no phase valid; BUSY: address and/or data phase valid;
    // ERR: second cycle of a two-cycle ERROR response
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } master_state_t;

endpackage

// File: rtl/peripheral_spram_ahb3_master_watchdog.sv
// Purpose: counts consecutive stalled data-phase cycles and flags expiry.
// Latency: expired is combinational in the TIMEOUT_CYCLES-th stalled cycle.
// Backpressure: none; counter clears whenever the stall is released.
// Only built when PERIPHERAL_SPRAM_AHB3_MASTER_TIMEOUT_EN is defined.
// Ports: clk/rst (sync, active-high), stall (data phase with HREADY low),
//        expired (one-cycle flag on the last allowed stall cycle).
`ifdef PERIPHERAL_SPRAM_AHB3_MASTER_TIMEOUT_EN
module peripheral_spram_ahb3_master_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    // count holds the number of stalled cycles already seen before this one
    logic [CW-1:0] count;

    assign expired = stall && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !stall || expired) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule
`endif

// File: rtl/peripheral_spram_ahb3_master.sv
// Purpose: pipelined AHB3-Lite single-transfer master fed by a valid/ready request port.
// Latency: address phase the cycle after acceptance, response pulse in the completing data-phase cycle.
// Backpressure: req_ready drops while the address phase is held by HREADY low or an ERROR is in progress.
// Optional watchdog: define PERIPHERAL_SPRAM_AHB3_MASTER_TIMEOUT_EN.
// Ports: HCLK/HRESET (sync, active-high); req_* request in; rsp_* response out
//        (rsp_valid is a pulse, no backpressure); H* AHB3-Lite master bus.
module peripheral_spram_ahb3_master
    import peripheral_ahb3_pkg::*;
#(
    parameter int PLEN           = 8,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [PLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_size,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_error,
    output logic            rsp_timeout,
    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic            HREADY,
    input  logic            HRESP
);
    // Widest transfer the data bus can carry, in HSIZE encoding
    localparam logic [2:0] SIZE_MAX = 3'($clog2(XLEN / 8));

    master_state_t   state, state_nx;
    logic            rdy_en;
    logic            a_vld, a_write, a_bad;
    logic [PLEN-1:0] a_addr;
    logic [2:0]      a_size;
    logic [XLEN-1:0] a_wdata;
    logic            d_vld, d_write, d_bad;
    logic [XLEN-1:0] hwdata_q;
    logic [1:0]      htrans_q;
    logic            hsel_q;
    logic            a_vld_nx, a_bad_nx, d_vld_nx, issue_nx;
    logic            accept, advance, err_start, err_done, req_bad, tmo_hit;

`ifdef PERIPHERAL_SPRAM_AHB3_MASTER_TIMEOUT_EN
    peripheral_spram_ahb3_master_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (HCLK),
        .rst     (HRESET),
        .stall   (d_vld && !HREADY),
        .expired (tmo_hit)
    );
`else
    assign tmo_hit = 1'b0;
`endif

    // Oversized requests travel the pipeline as bus-idle slots so their
    // error response stays in order with real transfers.
    assign req_bad   = (req_size > SIZE_MAX);
    assign req_ready = rdy_en && (!a_vld || HREADY) && (state != ST_ERR) && !tmo_hit;
    assign accept    = req_valid && req_ready;
    assign advance   = (state != ST_ERR) && HREADY && !tmo_hit;
    assign err_start = (state != ST_ERR) && d_vld && HRESP && !HREADY;
    assign err_done  = (state == ST_ERR) && HREADY && !tmo_hit;

    always_comb begin
        a_vld_nx = a_vld;
        a_bad_nx = a_bad;
        d_vld_nx = d_vld;
        state_nx = state;
        if (tmo_hit) begin
            a_vld_nx = 1'b0;
            d_vld_nx = 1'b0;
            state_nx = ST_IDLE;
        end else begin
            if (advance) begin
                d_vld_nx = a_vld;
                a_vld_nx = 1'b0;
            end
            if (err_done) begin
                d_vld_nx = 1'b0;
            end
            if (accept) begin
                a_vld_nx = 1'b1;
                a_bad_nx = req_bad;
            end
            if (err_start) begin
                state_nx = ST_ERR;
            end else if ((state != ST_ERR) || err_done) begin
                state_nx = (a_vld_nx || d_vld_nx) ? ST_BUSY : ST_IDLE;
            end
        end
        // While in ERR the held request is kept off the bus
        issue_nx = a_vld_nx && !a_bad_nx && (state_nx != ST_ERR);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            rdy_en   <= 1'b0;
            a_vld    <= 1'b0;
            a_bad    <= 1'b0;
            a_write  <= 1'b0;
            a_addr   <= '0;
            a_size   <= HSIZE_BYTE;
            a_wdata  <= '0;
            d_vld    <= 1'b0;
            d_write  <= 1'b0;
            d_bad    <= 1'b0;
            hwdata_q <= '0;
            htrans_q <= HTRANS_IDLE;
            hsel_q   <= 1'b0;
        end else begin
            rdy_en   <= 1'b1;
            state    <= state_nx;
            a_vld    <= a_vld_nx;
            a_bad    <= a_bad_nx;
            d_vld    <= d_vld_nx;
            htrans_q <= issue_nx ? HTRANS_NONSEQ : HTRANS_IDLE;
            hsel_q   <= issue_nx;
            if (accept) begin
                a_write <= req_write;
                a_addr  <= req_addr;
                a_size  <= req_size;
                a_wdata <= req_wdata;
            end
            if (advance) begin
                d_write  <= a_write;
                d_bad    <= a_bad;
                hwdata_q <= (a_vld && a_write && !a_bad) ? a_wdata : '0;
            end else if (!d_vld_nx) begin
                hwdata_q <= '0;
            end
        end
    end

    // Responses are taken in the cycle HRDATA/HRESP are valid, so they are
    // combinational from the data-phase registers and the slave handshake.
    assign rsp_valid   = d_vld && (HREADY || tmo_hit);
    assign rsp_error   = rsp_valid && (HRESP || d_bad || tmo_hit || (state == ST_ERR));
    assign rsp_timeout = tmo_hit;
    assign rsp_rdata   = (rsp_valid && !d_write && !d_bad && !tmo_hit) ? HRDATA : '0;

    assign HSEL      = hsel_q;
    assign HTRANS    = htrans_q;
    assign HADDR     = a_addr;
    assign HWRITE    = a_write;
    assign HSIZE     = a_size;
    assign HWDATA    = hwdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA_PRIV;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_peripheral_spram_ahb3_master.sv
// Purpose: directed self-checking bench for the AHB3-Lite master.
// Latency: inputs driven 2ns after each rising edge, outputs checked 1ns later.
// Backpressure: HREADY/HRESP are scripted per cycle; read data is a fixed address pattern.
module tb_peripheral_spram_ahb3_master;
    import peripheral_ahb3_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid, rsp_error, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [7:0]  HADDR;
    logic [31:0] HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    int compared = 0;
    int mismatched = 0;

    always #5 HCLK = ~HCLK;

    peripheral_spram_ahb3_master #(.PLEN(8), .XLEN(32), .TIMEOUT_CYCLES(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
    );

    // Read-only SPRAM slave: word at address A reads as 0xDA7A_00AA
    logic       sl_vld, sl_write;
    logic [7:0] sl_addr;
    always @(posedge HCLK) begin
        if (HRESET) begin
            sl_vld <= 1'b0;
        end else if (HREADY) begin
            sl_vld   <= HSEL && (HTRANS == 2'b10);
            sl_addr  <= HADDR;
            sl_write <= HWRITE;
        end
    end
    assign HRDATA = (sl_vld && !sl_write) ? (32'hDA7A_0000 | {24'h0, sl_addr}) : 32'hFFFF_FFFF;

    task automatic cyc();
        @(posedge HCLK);
        #2;
    endtask

    task automatic put_req(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [2:0] s);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_size = s;
    endtask

    task automatic test_reset();
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_size = HSIZE_WORD;
        HREADY = 1; HRESP = 0; HRESET = 1;
        cyc(); cyc(); #1;
        compared++; if (HTRANS !== 2'b00) begin mismatched++; $display("FAIL rst_htrans got %h want 0", HTRANS); end
        compared++; if (HSEL !== 1'b0) begin mismatched++; $display("FAIL rst_hsel got %b want 0", HSEL); end
        compared++; if (HADDR !== 8'h00 || HWDATA !== 32'h0) begin mismatched++; $display("FAIL rst_addr_data got %h/%h want 0/0", HADDR, HWDATA); end
        compared++; if (HWRITE !== 1'b0 || HSIZE !== 3'b000) begin mismatched++; $display("FAIL rst_write_size got %b/%h want 0/0", HWRITE, HSIZE); end
        compared++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin mismatched++; $display("FAIL rst_rsp got %b%b%b want 000", rsp_valid, rsp_error, rsp_timeout); end
        compared++; if (req_ready !== 1'b0) begin mismatched++; $display("FAIL rst_ready got %b want 0", req_ready); end
        compared++; if (HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin mismatched++; $display("FAIL const_ctrl got %h/%h/%b want 0/3/0", HBURST, HPROT, HMASTLOCK); end
        HRESET = 0; #1;
        compared++; if (req_ready !== 1'b0) begin mismatched++; $display("FAIL rst_ready_lag got %b want 0", req_ready); end
        cyc(); #1;
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready_rise got %b want 1", req_ready); end
    endtask

    task automatic test_write();
        cyc(); put_req(1'b1, 8'h10, 32'h1234_5678, HSIZE_WORD); #1;
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL wr_accept got %b want 1", req_ready); end
        cyc(); req_valid = 0; #1;
        compared++; if (HTRANS !== 2'b10 || HSEL !== 1'b1) begin mismatched++; $display("FAIL wr_addr_phase got htrans=%h hsel=%b want 2/1", HTRANS, HSEL); end
        compared++; if (HADDR !== 8'h10 || HWRITE !== 1'b1 || HSIZE !== 3'b010) begin mismatched++; $display("FAIL wr_addr_ctrl got %h/%b/%h want 10/1/2", HADDR, HWRITE, HSIZE); end
        compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL wr_rsp_early got %b want 0", rsp_valid); end
        cyc(); #1;
        compared++; if (HWDATA !== 32'h1234_5678) begin mismatched++; $display("FAIL wr_hwdata got %h want 12345678", HWDATA); end
        compared++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin mismatched++; $display("FAIL wr_rsp got v=%b e=%b d=%h want 1/0/0", rsp_valid, rsp_error, rsp_rdata); end
        compared++; if (HTRANS !== 2'b00) begin mismatched++; $display("FAIL wr_htrans_after got %h want 0", HTRANS); end
        cyc(); #1;
        compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL wr_rsp_pulse got %b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 7; k++) begin
            cyc();
            if (k < 4) put_req(1'b0, 8'(4 * k), 32'h0, HSIZE_WORD);
            else req_valid = 0;
            #1;
            if (k < 4) begin
                compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready k=%0d got %b want 1", k, req_ready); end
            end
            if (k >= 1 && k <= 4) begin
                compared++; if (HTRANS !== 2'b10 || HADDR !== 8'(4 * (k - 1))) begin mismatched++; $display("FAIL b2b_addr k=%0d got %h/%h want 2/%h", k, HTRANS, HADDR, 8'(4 * (k - 1))); end
            end
            if (k >= 2 && k <= 5) begin
                compared++; if (rsp_valid !== 1'b1 || rsp_rdata !== (32'hDA7A_0000 | 32'(4 * (k - 2)))) begin mismatched++; $display("FAIL b2b_rsp k=%0d got v=%b d=%h want 1/%h", k, rsp_valid, rsp_rdata, 32'hDA7A_0000 | 32'(4 * (k - 2))); end
            end else begin
                compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_norsp k=%0d got %b want 0", k, rsp_valid); end
            end
        end
    endtask

    task automatic test_wait_states();
        cyc(); put_req(1'b0, 8'h20, 32'h0, HSIZE_WORD); HREADY = 1; #1;
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL ws_accept0 got %b want 1", req_ready); end
        cyc(); put_req(1'b0, 8'h24, 32'h0, HSIZE_WORD); #1;
        compared++; if (HTRANS !== 2'b10 || HADDR !== 8'h20 || req_ready !== 1'b1) begin mismatched++; $display("FAIL ws_first got %h/%h/%b want 2/20/1", HTRANS, HADDR, req_ready); end
        for (int w = 0; w < 3; w++) begin
            cyc(); req_valid = 0; HREADY = 0; #1;
            compared++; if (HTRANS !== 2'b10 || HADDR !== 8'h24) begin mismatched++; $display("FAIL ws_hold w=%0d got %h/%h want 2/24", w, HTRANS, HADDR); end
            compared++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin mismatched++; $display("FAIL ws_stall w=%0d got v=%b r=%b want 0/0", w, rsp_valid, req_ready); end
        end
        cyc(); HREADY = 1; #1;
        compared++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDA7A_0020) begin mismatched++; $display("FAIL ws_rsp0 got v=%b d=%h want 1/da7a0020", rsp_valid, rsp_rdata); end
        compared++; if (HTRANS !== 2'b10 || HADDR !== 8'h24) begin mismatched++; $display("FAIL ws_last_addr got %h/%h want 2/24", HTRANS, HADDR); end
        cyc(); #1;
        compared++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDA7A_0024 || HTRANS !== 2'b00) begin mismatched++; $display("FAIL ws_rsp1 got v=%b d=%h t=%h want 1/da7a0024/0", rsp_valid, rsp_rdata, HTRANS); end
        cyc(); #1;
        compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL ws_done got %b want 0", rsp_valid); end
    endtask

    task automatic test_error();
        cyc(); put_req(1'b1, 8'h30, 32'hCAFE_F00D, HSIZE_WORD); HREADY = 1; HRESP = 0; #1;
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL er_accept0 got %b want 1", req_ready); end
        cyc(); put_req(1'b0, 8'h34, 32'h0, HSIZE_WORD); #1;
        compared++; if (HTRANS !== 2'b10 || HADDR !== 8'h30 || HWRITE !== 1'b1 || req_ready !== 1'b1) begin mismatched++; $display("FAIL er_addr0 got %h/%h/%b/%b want 2/30/1/1", HTRANS, HADDR, HWRITE, req_ready); end
        cyc(); req_valid = 0; HREADY = 0; HRESP = 1; #1;
        compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL er_cycle1_rsp got %b want 0", rsp_valid); end
        compared++; if (HTRANS !== 2'b10 || HADDR !== 8'h34 || HWDATA !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL er_cycle1_bus got %h/%h/%h want 2/34/cafef00d", HTRANS, HADDR, HWDATA); end
        cyc(); HREADY = 1; HRESP = 1; #1;
        compared++; if (HTRANS !== 2'b00 || HSEL !== 1'b0) begin mismatched++; $display("FAIL er_idle got %h/%b want 0/0", HTRANS, HSEL); end
        compared++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || req_ready !== 1'b0) begin mismatched++; $display("FAIL er_rsp got v=%b e=%b r=%b want 1/1/0", rsp_valid, rsp_error, req_ready); end
        cyc(); HREADY = 1; HRESP = 0; #1;
        compared++; if (HTRANS !== 2'b10 || HADDR !== 8'h34 || HWRITE !== 1'b0 || rsp_valid !== 1'b0) begin mismatched++; $display("FAIL er_reissue got %h/%h/%b/%b want 2/34/0/0", HTRANS, HADDR, HWRITE, rsp_valid); end
        cyc(); #1;
        compared++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'hDA7A_0034) begin mismatched++; $display("FAIL er_rsp1 got v=%b e=%b d=%h want 1/0/da7a0034", rsp_valid, rsp_error, rsp_rdata); end
        cyc(); #1;
        compared++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin mismatched++; $display("FAIL er_done got %h/%b want 0/0", HTRANS, rsp_valid); end
    endtask

    task automatic test_unsupported();
        cyc(); put_req(1'b0, 8'h40, 32'h0, 3'b011); HREADY = 1; #1;
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL us_accept got %b want 1", req_ready); end
        cyc(); req_valid = 0; #1;
        compared++; if (HTRANS !== 2'b00 || HSEL !== 1'b0 || rsp_valid !== 1'b0) begin mismatched++; $display("FAIL us_nobus got %h/%b/%b want 0/0/0", HTRANS, HSEL, rsp_valid); end
        cyc(); #1;
        compared++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || HTRANS !== 2'b00) begin mismatched++; $display("FAIL us_rsp got v=%b e=%b t=%h want 1/1/0", rsp_valid, rsp_error, HTRANS); end
        cyc(); #1;
        compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL us_done got %b want 0", rsp_valid); end
    endtask

    task automatic test_timeout();
        cyc(); put_req(1'b0, 8'h00, 32'h0, HSIZE_WORD); HREADY = 1; #1;
        cyc(); req_valid = 0; #1;
        compared++; if (HTRANS !== 2'b10 || HADDR !== 8'h00) begin mismatched++; $display("FAIL to_addr got %h/%h want 2/00", HTRANS, HADDR); end
`ifdef PERIPHERAL_SPRAM_AHB3_MASTER_TIMEOUT_EN
        for (int w = 1; w <= 16; w++) begin
            cyc(); HREADY = 0; #1;
            if (w < 16) begin
                compared++; if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin mismatched++; $display("FAIL to_wait w=%0d got v=%b t=%b want 0/0", w, rsp_valid, rsp_timeout); end
            end else begin
                compared++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_timeout !== 1'b1) begin mismatched++; $display("FAIL to_hit got v=%b e=%b t=%b want 1/1/1", rsp_valid, rsp_error, rsp_timeout); end
            end
        end
        cyc(); HREADY = 1; #1;
        compared++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin mismatched++; $display("FAIL to_after got %h/%b/%b want 0/0/1", HTRANS, rsp_valid, req_ready); end
`else
        for (int w = 1; w <= 20; w++) begin
            cyc(); HREADY = 0; #1;
            compared++; if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin mismatched++; $display("FAIL nt_wait w=%0d got v=%b t=%b want 0/0", w, rsp_valid, rsp_timeout); end
        end
        cyc(); HREADY = 1; #1;
        compared++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'hDA7A_0000) begin mismatched++; $display("FAIL nt_rsp got v=%b e=%b t=%b d=%h want 1/0/0/da7a0000", rsp_valid, rsp_error, rsp_timeout, rsp_rdata); end
        cyc(); #1;
        compared++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin mismatched++; $display("FAIL nt_done got %h/%b want 0/0", HTRANS, rsp_valid); end
`endif
    endtask

    task automatic test_reset_mid();
        cyc(); put_req(1'b1, 8'h08, 32'h55AA_55AA, HSIZE_WORD); HREADY = 1; #1;
        cyc(); req_valid = 0; #1;
        cyc(); HREADY = 0; HRESET = 1; #1;
        compared++; if (HWDATA !== 32'h55AA_55AA || rsp_valid !== 1'b0) begin mismatched++; $display("FAIL rm_wait got d=%h v=%b want 55aa55aa/0", HWDATA, rsp_valid); end
        cyc(); HRESET = 0; HREADY = 1; #1;
        compared++; if (HTRANS !== 2'b00 || HSEL !== 1'b0 || HADDR !== 8'h00) begin mismatched++; $display("FAIL rm_addr got %h/%b/%h want 0/0/00", HTRANS, HSEL, HADDR); end
        compared++; if (HWDATA !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== 3'b000) begin mismatched++; $display("FAIL rm_data got %h/%b/%h want 0/0/0", HWDATA, HWRITE, HSIZE); end
        compared++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0 || req_ready !== 1'b0) begin mismatched++; $display("FAIL rm_rsp got %b%b%b r=%b want 000 r=0", rsp_valid, rsp_error, rsp_timeout, req_ready); end
        cyc(); #1;
        compared++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || HTRANS !== 2'b00) begin mismatched++; $display("FAIL rm_after got v=%b r=%b t=%h want 0/1/0", rsp_valid, req_ready, HTRANS); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_unsupported();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
